// File: rtl/alu_cmd_sequencer_if.sv
// Byte-stream and ALU bus bundle between the command sequencer and its
// surroundings (UART RX/TX paths and the combinational ALU).
interface alu_cmd_sequencer_if #(
  parameter int NB_DATA    = 8,
  parameter int NB_OP_CODE = 6
);
  // UART RX stream into the sequencer
  logic [NB_DATA-1:0]    i_rx_data;
  logic                  i_rx_valid;
  logic                  o_rx_ready;
  // UART TX stream out of the sequencer
  logic [NB_DATA-1:0]    o_tx_data;
  logic                  o_tx_valid;
  logic                  i_tx_ready;
  // ALU operands out, ALU results back
  logic [NB_DATA-1:0]    o_alu_data_a;
  logic [NB_DATA-1:0]    o_alu_data_b;
  logic [NB_OP_CODE-1:0] o_alu_op_code;
  logic [NB_DATA-1:0]    i_alu_result;
  logic                  i_alu_zero;
  logic                  i_alu_carry;
  // Status
  logic                  o_busy;
  logic                  o_op_error;

  // Sequencer side
  modport master (
    input  i_rx_data, i_rx_valid, i_tx_ready,
    input  i_alu_result, i_alu_zero, i_alu_carry,
    output o_rx_ready, o_tx_data, o_tx_valid,
    output o_alu_data_a, o_alu_data_b, o_alu_op_code,
    output o_busy, o_op_error
  );

  // UART / ALU side
  modport slave (
    output i_rx_data, i_rx_valid, i_tx_ready,
    output i_alu_result, i_alu_zero, i_alu_carry,
    input  o_rx_ready, o_tx_data, o_tx_valid,
    input  o_alu_data_a, o_alu_data_b, o_alu_op_code,
    input  o_busy, o_op_error
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the combinational ALU: collects A, B and op code
// from the RX byte stream, runs one ALU evaluation and returns the result
// byte followed by a flags byte {0.., carry, zero} on the TX stream.
module alu_cmd_sequencer #(
  parameter int NB_DATA    = 8,
  parameter int NB_OP_CODE = 6
) (
  input  logic             clock,
  input  logic             i_reset_n,
  alu_cmd_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    GET_A, GET_B, GET_OP, EXEC, SEND_RES, SEND_FLAGS
  } state_t;

  localparam logic [NB_OP_CODE-1:0] OP_ADD = NB_OP_CODE'(6'b100000);
  localparam logic [NB_OP_CODE-1:0] OP_SUB = NB_OP_CODE'(6'b100010);
  localparam logic [NB_OP_CODE-1:0] OP_AND = NB_OP_CODE'(6'b100100);
  localparam logic [NB_OP_CODE-1:0] OP_OR  = NB_OP_CODE'(6'b100101);
  localparam logic [NB_OP_CODE-1:0] OP_XOR = NB_OP_CODE'(6'b100110);
  localparam logic [NB_OP_CODE-1:0] OP_SRA = NB_OP_CODE'(6'b000011);
  localparam logic [NB_OP_CODE-1:0] OP_SRL = NB_OP_CODE'(6'b000010);
  localparam logic [NB_OP_CODE-1:0] OP_NOR = NB_OP_CODE'(6'b100111);

  state_t                state_reg, state_next;
  logic [NB_DATA-1:0]    data_a_reg, data_a_next;
  logic [NB_DATA-1:0]    data_b_reg, data_b_next;
  logic [NB_OP_CODE-1:0] op_code_reg, op_code_next;
  logic [NB_DATA-1:0]    tx_data_reg, tx_data_next;
  logic                  tx_valid_reg, tx_valid_next;
  logic                  zero_reg, zero_next;
  logic                  carry_reg, carry_next;
  logic                  op_error_reg, op_error_next;

  logic                  rx_ready;
  logic                  rx_accept;
  logic                  tx_accept;
  logic [NB_OP_CODE-1:0] op_in;

  function automatic logic op_supported(input logic [NB_OP_CODE-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Handshake qualifiers; only the op-code bits of the third byte are used
  always_comb begin
    rx_ready  = (state_reg == GET_A) || (state_reg == GET_B) || (state_reg == GET_OP);
    rx_accept = bus.i_rx_valid & rx_ready;
    tx_accept = tx_valid_reg & bus.i_tx_ready;
    op_in     = bus.i_rx_data[NB_OP_CODE-1:0];
  end

  // Next-state and datapath update for the command FSM
  always_comb begin
    state_next    = state_reg;
    data_a_next   = data_a_reg;
    data_b_next   = data_b_reg;
    op_code_next  = op_code_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    zero_next     = zero_reg;
    carry_next    = carry_reg;
    op_error_next = 1'b0;
    case (state_reg)
      GET_A: begin
        if (rx_accept) begin
          data_a_next = bus.i_rx_data;
          state_next  = GET_B;
        end
      end
      GET_B: begin
        if (rx_accept) begin
          data_b_next = bus.i_rx_data;
          state_next  = GET_OP;
        end
      end
      GET_OP: begin
        if (rx_accept) begin
          if (op_supported(op_in)) begin
            op_code_next = op_in;
            state_next   = EXEC;
          end else begin
            // Drop the command silently apart from the error pulse
            op_error_next = 1'b1;
            state_next    = GET_A;
          end
        end
      end
      EXEC: begin
        // Operands have been stable for a full cycle; sample the ALU now
        zero_next     = bus.i_alu_zero;
        carry_next    = bus.i_alu_carry;
        tx_data_next  = bus.i_alu_result;
        tx_valid_next = 1'b1;
        state_next    = SEND_RES;
      end
      SEND_RES: begin
        if (tx_accept) begin
          // Valid stays high so the flags byte follows without a bubble
          tx_data_next = {{(NB_DATA-2){1'b0}}, carry_reg, zero_reg};
          state_next   = SEND_FLAGS;
        end
      end
      SEND_FLAGS: begin
        if (tx_accept) begin
          tx_valid_next = 1'b0;
          state_next    = GET_A;
        end
      end
      default: state_next = GET_A;
    endcase
  end

  // State and datapath registers; reset discards any partial command
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg    <= GET_A;
      data_a_reg   <= '0;
      data_b_reg   <= '0;
      op_code_reg  <= '0;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
      zero_reg     <= 1'b0;
      carry_reg    <= 1'b0;
      op_error_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      data_a_reg   <= data_a_next;
      data_b_reg   <= data_b_next;
      op_code_reg  <= op_code_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      zero_reg     <= zero_next;
      carry_reg    <= carry_next;
      op_error_reg <= op_error_next;
    end
  end

  // Output drive; ready is held low while reset is asserted
  always_comb begin
    bus.o_rx_ready    = rx_ready & i_reset_n;
    bus.o_tx_data     = tx_data_reg;
    bus.o_tx_valid    = tx_valid_reg;
    bus.o_alu_data_a  = data_a_reg;
    bus.o_alu_data_b  = data_b_reg;
    bus.o_alu_op_code = op_code_reg;
    bus.o_busy        = (state_reg != GET_A);
    bus.o_op_error    = op_error_reg;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command front-end that drives the combinational ALU.
- Receives a byte stream from the UART RX path and collects operand A, operand B and the op code.
- Presents the collected values to the ALU, captures result, zero and carry, and returns two bytes (result, flags) on the UART TX stream.
- Sits between the UART and the ALU instance in the top level.

Parameters:
- NB_DATA, 8, datapath/byte width; must be >= 2.
- NB_OP_CODE, 6, ALU op code width; must be <= NB_DATA.

Ports:
- clock  in  1  system clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_rx_data  in  NB_DATA  incoming command byte.
- i_rx_valid  in  1  i_rx_data valid.
- o_rx_ready  out  1  sequencer can accept a byte.
- o_tx_data  out  NB_DATA  outgoing response byte.
- o_tx_valid  out  1  o_tx_data valid.
- i_tx_ready  in  1  TX path accepts o_tx_data.
- o_alu_data_a  out  NB_DATA  ALU operand A (registered).
- o_alu_data_b  out  NB_DATA  ALU operand B (registered).
- o_alu_op_code  out  NB_OP_CODE  ALU op code (registered).
- i_alu_result  in  NB_DATA  ALU result.
- i_alu_zero  in  1  ALU zero flag.
- i_alu_carry  in  1  ALU carry flag.
- o_busy  out  1  command in progress.
- o_op_error  out  1  one-cycle pulse on unsupported op code.

Behaviour:
- Reset (async, i_reset_n=0):
  - State goes to GET_A.
  - o_alu_data_a, o_alu_data_b, o_alu_op_code, o_tx_data, result/flag registers = 0.
  - o_tx_valid = 0, o_op_error = 0, o_busy = 0.
  - o_rx_ready = 1 once reset is released.
  - Reset asserted mid-command discards all partial data; no response is sent.
- Handshakes:
  - RX byte is consumed on a rising edge with i_rx_valid & o_rx_ready.
  - TX byte is consumed on a rising edge with o_tx_valid & i_tx_ready.
  - o_tx_data and o_tx_valid are registered and held stable until consumed.
- FSM states: GET_A, GET_B, GET_OP, EXEC, SEND_RES, SEND_FLAGS.
  - GET_A: o_rx_ready=1. On accept, o_alu_data_a <= i_rx_data; go to GET_B.
  - GET_B: o_rx_ready=1. On accept, o_alu_data_b <= i_rx_data; go to GET_OP.
  - GET_OP: o_rx_ready=1. On accept, take op = i_rx_data[NB_OP_CODE-1:0]; upper bits are ignored.
    - Supported op: o_alu_op_code <= op; go to EXEC.
    - Unsupported op: o_op_error=1 for exactly one cycle (the cycle after accept); o_alu_op_code unchanged; return to GET_A; nothing transmitted.
  - Supported op codes:
    - ADD 100000, SUB 100010, AND 100100, OR 100101
    - XOR 100110, SRA 000011, SRL 000010, NOR 100111
  - EXEC: one cycle with o_rx_ready=0, so the ALU inputs settle. On the edge, capture i_alu_result, i_alu_zero, i_alu_carry; load o_tx_data <= result; o_tx_valid <= 1; go to SEND_RES.
  - SEND_RES: on TX accept, o_tx_data <= {(NB_DATA-2) zeros, carry, zero}; o_tx_valid stays 1; go to SEND_FLAGS.
  - SEND_FLAGS: on TX accept, o_tx_valid <= 0; go to GET_A.
- Latency: op byte accepted at edge N, result byte valid after edge N+1. Back-to-back TX accepts produce no bubble between the result and flags bytes.
- o_rx_ready = 0 in EXEC, SEND_RES and SEND_FLAGS; RX bytes offered then are not consumed.
- o_busy = 1 in every state except GET_A.
- ALU outputs hold their last values between commands.
- The sequencer does not compute flags; it forwards whatever the ALU reports.

Test Plan:
- ADD: RX 0xC8, 0x64, 0x20; i_tx_ready=1 -> TX 0x2C then 0x02 (carry=1, zero=0); o_alu_op_code=0x20; result valid 1 cycle after op accept.
- SUB equal: RX 0x05, 0x05, 0x22 -> TX 0x00 then 0x03 (zero=1, carry=1); then o_busy=0 and o_rx_ready=1.
- Op masking and SRA: RX 0x80, 0x03, 0xC3 -> o_alu_op_code=0x03; TX 0xF0 then 0x00.
- Unsupported op: RX 0x10, 0x20, 0x3F -> o_op_error high exactly 1 cycle, no o_tx_valid; o_alu_op_code keeps previous value. A following AND command (0xF0, 0x3C, 0x24) -> TX 0x30, 0x00.
- TX backpressure: ADD 0x01+0x01 with i_tx_ready=0 for 5 cycles -> o_tx_data=0x02 and o_tx_valid=1 stable throughout; RX bytes offered meanwhile are not consumed; flags byte 0x00 follows after ready rises.
- Reset mid-command: RX 0xAA, 0x55, then assert i_reset_n=0 asynchronously -> all outputs 0 immediately. After release, RX 0x01, 0x02, 0x20 -> TX 0x03, 0x00 (old bytes discarded).
